ebus_diag_master: RTL and testbench
===================================

Name: ebus_diag_master

Overview:
Front-end (console) side of the EBUS diagnostic protocol.
- Accepts one diagnostic request at a time from the console processor model.
- Sequences the EBUS diagnostic cycle: drive the function/select code, settle, then either strobe (control/write functions) or sample returned data (read functions).
- Returns one response per request.
- Is the initiator for the EBOX diagnostic responders: CON run/start/continue, IR/DRAM strobes, and the 18–24 diag read muxes.

Parameters:
- SETTLE_CYCLES, 4: cycles the select code and data are held before strobe or sample; must be ≥1.
- STROBE_CYCLES, 2: width of the diag_strobe pulse; must be ≥1.

Ports:
- clk, input, 1: single clock.
- RESET, input, 1: synchronous, active-high reset.
- req_valid, input, 1: request offered.
- req_ready, output, 1: block idle and able to accept a request.
- req_func, input, [0:6]: diagnostic function code, KL10 bit order.
- req_read, input, 1: 1 = read function (sample data), 0 = control/write function (strobe).
- req_data, input, [0:35]: data driven for write functions.
- rsp_valid, output, 1: response available.
- rsp_ready, input, 1: response consumed.
- rsp_data, output, [0:35]: sampled EBUS data for reads; 0 for writes.
- rsp_par_err, output, 1: parity error on a read sample; 0 for writes.
- ds, output, [0:6]: EBUS diagnostic select code.
- diag_strobe, output, 1: diagnostic function strobe.
- data_drive, output, 1: master drives EBUS data.
- data_out, output, [0:35]: EBUS data driven by the master.
- data_in, input, [0:35]: EBUS data from the responders.
- parity_in, input, 1: EBUS parity bit.

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_par_err=0; ds=0; diag_strobe=0; data_drive=0; data_out=0; counter=0.
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- Accept: handshake completes on a clock edge where req_valid & req_ready.
  - Latch func, read, data.
  - Go to SETUP with counter=SETTLE_CYCLES-1.
  - req_ready=0 from the next cycle until the return to IDLE.
- SETUP:
  - ds = latched func.
  - data_drive = ~read; data_out = latched data if write, else 0.
  - Counter decrements each cycle. At counter==0:
    - Read: capture rsp_data=data_in; rsp_par_err = ~(^{data_in,parity_in}) (odd parity expected); go to RESP.
    - Write: go to STROBE with counter=STROBE_CYCLES-1.
- STROBE: diag_strobe=1; ds and data held. At counter==0, go to HOLD.
- HOLD: exactly one cycle with diag_strobe=0 and ds/data still held (hold time). Then go to RESP with rsp_data=0 and rsp_par_err=0.
- RESP:
  - rsp_valid=1; ds=0; data_drive=0; data_out=0.
  - rsp_data and rsp_par_err are stable until accepted.
  - On rsp_valid & rsp_ready, go to IDLE; req_ready=1 the following cycle.
- Latency, counted from the accept edge to the first cycle with rsp_valid:
  - Read: SETTLE_CYCLES+1 cycles.
  - Write: SETTLE_CYCLES+STROBE_CYCLES+2 cycles.
  - With defaults: read 5, write 8.
  - Minimum request-to-request spacing = latency + 1 (accept cycle).
- req_valid while not ready: ignored, no side effects. The requester must hold the request.
- rsp_ready held low: remain in RESP indefinitely. No timeout.
- rsp_ready high before rsp_valid: no effect.
- RESET asserted in any state, including mid-strobe: next edge forces all reset values.
  - The in-flight request is dropped with no response.
  - diag_strobe never extends past that edge.
- RESET and req_valid in the same cycle: reset wins; the request is not accepted.
- ds is never changed while diag_strobe=1. diag_strobe is never 1 in a read cycle.
- Counter width: $clog2(max(SETTLE_CYCLES,STROBE_CYCLES))+1. Compare to zero only, so there is no wrap.
- Outputs are registered. No combinational path from req_* or rsp_ready to EBUS outputs.

Decomposition:
- Package ebus_diag_pkg holds:
  - The state enum.
  - Function code constants: FUNC_CLR_RUN=7'o010, FUNC_SET_RUN=7'o011, FUNC_CONTINUE=7'o012, FUNC_IR_STROBE=7'o014, FUNC_DRAM_STROBE=7'o015, FUNC_READ_13x base=7'o130.
  - The 36-bit word typedef.
- One sub-module: ebus_parity36, combinational odd-parity check over 36 data bits plus the parity bit, outputting err. It is reused by other EBUS endpoints.

Test Plan:
- Reset then write FUNC_SET_RUN (req_func=7'o011, req_read=0), defaults:
  - ds=7'o011 on cycles 1–7.
  - diag_strobe=1 exactly on cycles 5–6, 0 on cycle 7.
  - rsp_valid on cycle 8 with rsp_data=0.
  - req_ready=1 the cycle after the rsp handshake.
- Read 7'o131, responder returns data_in=36'o000123000000 with correct odd parity:
  - diag_strobe stays 0.
  - rsp_valid at cycle 5; rsp_data=36'o000123000000; rsp_par_err=0.
- Same read with parity_in inverted -> rsp_par_err=1, rsp_data unchanged.
- Hold rsp_ready=0 for 10 cycles after the write response:
  - rsp_valid and rsp_data stable; req_ready=0; a second req_valid is ignored.
  - After rsp_ready=1, the second request is accepted the next ready cycle.
- Assert RESET during STROBE (cycle 5) -> next edge: diag_strobe=0, ds=0, data_drive=0, req_ready=1, and no rsp_valid ever issued.
- SETTLE_CYCLES=1, STROBE_CYCLES=1:
  - Write rsp_valid at cycle 4, read at cycle 2.
  - Back-to-back CONTINUE then DRAM_STROBE with rsp_ready tied high: two distinct strobe pulses, with ds changing only while the strobe is low.

Source files
------------

// File: rtl/ebus_diag_pkg.sv
// ebus_diag_pkg
//   Shared definitions for the EBUS diagnostic master and its helpers:
//   FSM state codes, the 36-bit EBUS word type (KL10 bit order, bit 0 = MSB),
//   diagnostic function codes, and the EBUS odd-parity check function.
package ebus_diag_pkg;

    typedef logic [0:35] word_t;
    typedef logic [0:6]  func_t;
    typedef logic [2:0]  state_t;

    // FSM states, kept as plain constants so older tooling can read them
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_STROBE = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

    // Diagnostic function codes understood by the EBOX responders
    localparam func_t FUNC_CLR_RUN     = 7'o010;
    localparam func_t FUNC_SET_RUN     = 7'o011;
    localparam func_t FUNC_CONTINUE    = 7'o012;
    localparam func_t FUNC_IR_STROBE   = 7'o014;
    localparam func_t FUNC_DRAM_STROBE = 7'o015;
    localparam func_t FUNC_READ_13X    = 7'o130;

    // EBUS words carry odd parity: data plus parity bit must hold an odd
    // number of ones, so an even total is an error.
    function automatic logic odd_parity_err(input word_t data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/ebus_parity36.sv
// ebus_parity36
//   Combinational odd-parity checker for one EBUS word; shared by EBUS endpoints.
//   Ports:
//     data [0:35] in  - EBUS data word
//     par         in  - EBUS parity bit
//     err         out - 1 when {data,par} does not have odd parity
module ebus_parity36
    import ebus_diag_pkg::*;
(
    input  logic [0:35] data,
    input  logic        par,
    output logic        err
);

    assign err = odd_parity_err(data, par);

endmodule

// File: rtl/ebus_diag_master.sv
// ebus_diag_master
//   Console-side initiator of the EBUS diagnostic cycle. Takes one request at
//   a time, drives the select code (and write data) for SETTLE_CYCLES, then
//   either pulses diag_strobe for STROBE_CYCLES plus one hold cycle (control/
//   write functions) or samples data_in with a parity check (read functions),
//   and returns exactly one response per request.
//   Ports:
//     clk, RESET                      - clock, synchronous active-high reset
//     req_valid/req_ready             - request handshake
//     req_func/req_read/req_data      - function code, read flag, write data
//     rsp_valid/rsp_ready             - response handshake
//     rsp_data/rsp_par_err            - read data and parity error (0 on writes)
//     ds/diag_strobe                  - EBUS select code and function strobe
//     data_drive/data_out             - master EBUS data enable and value
//     data_in/parity_in               - EBUS data and parity from responders
//   All outputs are registered.
module ebus_diag_master
    import ebus_diag_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:6]  req_func,
    input  logic        req_read,
    input  logic [0:35] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:35] rsp_data,
    output logic        rsp_par_err,
    output logic [0:6]  ds,
    output logic        diag_strobe,
    output logic        data_drive,
    output logic [0:35] data_out,
    input  logic [0:35] data_in,
    input  logic        parity_in
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > STROBE_CYCLES) ? SETTLE_CYCLES : STROBE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          read_r;
    logic          req_ready_r;
    logic          rsp_valid_r;
    word_t         rsp_data_r;
    logic          rsp_par_err_r;
    func_t         ds_r;
    logic          diag_strobe_r;
    logic          data_drive_r;
    word_t         data_out_r;
    logic          par_err_s;

    ebus_parity36 u_parity (
        .data (data_in),
        .par  (parity_in),
        .err  (par_err_s)
    );

    // Diagnostic cycle sequencer; every output is a register updated here
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            read_r        <= 1'b0;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 36'o0;
            rsp_par_err_r <= 1'b0;
            ds_r          <= 7'o0;
            diag_strobe_r <= 1'b0;
            data_drive_r  <= 1'b0;
            data_out_r    <= 36'o0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        state_r      <= ST_SETUP;
                        cnt_r        <= SETTLE_LOAD;
                        read_r       <= req_read;
                        req_ready_r  <= 1'b0;
                        ds_r         <= req_func;
                        data_drive_r <= ~req_read;
                        data_out_r   <= req_read ? 36'o0 : req_data;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (read_r) begin
                            // Sample taken on the last settle cycle; bus released for RESP
                            state_r       <= ST_RESP;
                            rsp_valid_r   <= 1'b1;
                            rsp_data_r    <= data_in;
                            rsp_par_err_r <= par_err_s;
                            ds_r          <= 7'o0;
                            data_drive_r  <= 1'b0;
                            data_out_r    <= 36'o0;
                        end else begin
                            state_r       <= ST_STROBE;
                            cnt_r         <= STROBE_LOAD;
                            diag_strobe_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_STROBE: begin
                    if (cnt_r == CNT_ZERO) begin
                        // Strobe drops first; ds/data stay for one hold cycle
                        state_r       <= ST_HOLD;
                        diag_strobe_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    state_r       <= ST_RESP;
                    rsp_valid_r   <= 1'b1;
                    rsp_data_r    <= 36'o0;
                    rsp_par_err_r <= 1'b0;
                    ds_r          <= 7'o0;
                    data_drive_r  <= 1'b0;
                    data_out_r    <= 36'o0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe idle bus
                    state_r       <= ST_IDLE;
                    cnt_r         <= CNT_ZERO;
                    req_ready_r   <= 1'b1;
                    rsp_valid_r   <= 1'b0;
                    ds_r          <= 7'o0;
                    diag_strobe_r <= 1'b0;
                    data_drive_r  <= 1'b0;
                    data_out_r    <= 36'o0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_par_err = rsp_par_err_r;
    assign ds          = ds_r;
    assign diag_strobe = diag_strobe_r;
    assign data_drive  = data_drive_r;
    assign data_out    = data_out_r;

endmodule

// File: tb/tb_ebus_diag_master.sv
// tb_ebus_diag_master
//   Self-checking bench for ebus_diag_master. Instance 0 uses the default
//   timing (settle 4, strobe 2); instance 1 uses settle 1, strobe 1.
//   Expected behaviour is derived per transaction from the protocol timeline:
//   latency, strobe window, held select code, and odd-parity expectation.
module tb_ebus_diag_master;
    import ebus_diag_pkg::*;

    logic        clk;
    logic        rst         [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [0:6]  req_func    [2];
    logic        req_read    [2];
    logic [0:35] req_data    [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [0:35] rsp_data    [2];
    logic        rsp_par_err [2];
    logic [0:6]  ds          [2];
    logic        diag_strobe [2];
    logic        data_drive  [2];
    logic [0:35] data_out    [2];
    logic [0:35] data_in     [2];
    logic        parity_in   [2];

    int checks = 0;
    int errors = 0;

    ebus_diag_master dut0 (
        .clk(clk), .RESET(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_func(req_func[0]), .req_read(req_read[0]), .req_data(req_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_par_err(rsp_par_err[0]), .ds(ds[0]), .diag_strobe(diag_strobe[0]),
        .data_drive(data_drive[0]), .data_out(data_out[0]), .data_in(data_in[0]),
        .parity_in(parity_in[0])
    );

    ebus_diag_master #(.SETTLE_CYCLES(1), .STROBE_CYCLES(1)) dut1 (
        .clk(clk), .RESET(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_func(req_func[1]), .req_read(req_read[1]), .req_data(req_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_par_err(rsp_par_err[1]), .ds(ds[1]), .diag_strobe(diag_strobe[1]),
        .data_drive(data_drive[1]), .data_out(data_out[1]), .data_in(data_in[1]),
        .parity_in(parity_in[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus rules checked every cycle: ds frozen around a strobe pulse, no strobe on reads
    logic       rst_at_edge [2];
    logic       stb_prev    [2];
    logic [0:6] ds_prev     [2];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) rst_at_edge[u] = rst[u];
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_at_edge[u] === 1'b0 && (stb_prev[u] === 1'b1 || diag_strobe[u] === 1'b1))
                chk("ds_frozen_in_strobe", ds[u], ds_prev[u]);
            if (diag_strobe[u] === 1'b1)
                chk("strobe_only_on_write", data_drive[u], 1);
            stb_prev[u] = diag_strobe[u];
            ds_prev[u]  = ds[u];
        end
    end

    // One full request/response, starting at a negedge with the DUT idle
    task automatic txn(input int u, input logic [0:6] f, input logic rd, input logic [0:35] wd,
                       input logic [0:35] din, input logic pin, input int delay,
                       input logic early, input logic spur);
        int          s, t, lat;
        logic [0:35] exp_rd;
        logic        exp_pe, exp_stb;
        s      = (u == 0) ? 4 : 1;
        t      = (u == 0) ? 2 : 1;
        lat    = rd ? s + 1 : s + t + 2;
        exp_rd = rd ? din : 36'o0;
        exp_pe = rd ? ($countones({din, pin}) % 2 == 0) : 1'b0;
        chk("req_ready_idle", req_ready[u], 1);
        req_valid[u] = 1'b1; req_func[u] = f; req_read[u] = rd; req_data[u] = wd;
        data_in[u] = din; parity_in[u] = pin; rsp_ready[u] = early;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid[u] = 1'b0;
                req_func[u]  = 7'($urandom);
                req_read[u]  = 1'($urandom);
                req_data[u]  = {4'($urandom), $urandom};
            end
            if (k < lat) begin
                exp_stb = !rd && k >= s + 1 && k <= s + t;
                chk("ds_held", ds[u], f);
                chk("strobe", diag_strobe[u], exp_stb);
                chk("data_drive", data_drive[u], !rd);
                chk("data_out", data_out[u], rd ? 36'o0 : wd);
                chk("no_rsp_early", rsp_valid[u], 0);
                chk("busy", req_ready[u], 0);
            end else begin
                chk("rsp_valid", rsp_valid[u], 1);
                chk("rsp_data", rsp_data[u], exp_rd);
                chk("rsp_par_err", rsp_par_err[u], exp_pe);
                chk("ds_released", ds[u], 0);
                chk("strobe_off", diag_strobe[u], 0);
                chk("drive_off", data_drive[u], 0);
                data_in[u]   = {4'($urandom), $urandom};
                parity_in[u] = 1'($urandom);
            end
        end
        for (int d = 0; d < delay; d++) begin
            if (spur) begin
                req_valid[u] = 1'b1; req_func[u] = ~f; req_read[u] = 1'b0;
            end
            @(negedge clk);
            chk("rsp_hold_valid", rsp_valid[u], 1);
            chk("rsp_hold_data", rsp_data[u], exp_rd);
            chk("rsp_hold_pe", rsp_par_err[u], exp_pe);
            chk("rsp_hold_busy", req_ready[u], 0);
            chk("rsp_hold_ds", ds[u], 0);
        end
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = early;
        req_valid[u] = 1'b0;
        chk("rsp_done", rsp_valid[u], 0);
        chk("ready_again", req_ready[u], 1);
    endtask

    initial begin
        logic [0:35] w;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req_valid[u] = 1'b1; req_func[u] = FUNC_SET_RUN; req_read[u] = 1'b0;
            req_data[u] = 36'o777777777777; rsp_ready[u] = 1'b0;
            data_in[u] = 36'o0; parity_in[u] = 1'b1;
        end
        // Reset with a request pending: reset wins
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b0; req_valid[u] = 1'b0;
            chk("rst_req_ready", req_ready[u], 1);
            chk("rst_rsp_valid", rsp_valid[u], 0);
            chk("rst_rsp_data", rsp_data[u], 0);
            chk("rst_rsp_pe", rsp_par_err[u], 0);
            chk("rst_ds", ds[u], 0);
            chk("rst_strobe", diag_strobe[u], 0);
            chk("rst_drive", data_drive[u], 0);
            chk("rst_data_out", data_out[u], 0);
        end
        @(negedge clk);
        chk("rst_no_accept0", req_ready[0], 1);
        chk("rst_no_accept1", ds[1], 0);

        // Default timing: SET RUN write, then read of 131 with good and bad parity
        txn(0, FUNC_SET_RUN, 1'b0, 36'o123456701234, 36'o0, 1'b0, 0, 1'b0, 1'b0);
        w = 36'o000123000000;
        txn(0, FUNC_READ_13X + 7'o001, 1'b1, 36'o0, w, ~(^w), 0, 1'b0, 1'b0);
        txn(0, FUNC_READ_13X + 7'o001, 1'b1, 36'o0, w, ^w, 0, 1'b0, 1'b0);
        // Response held off 10 cycles with a spurious request waiting behind it
        txn(0, FUNC_CLR_RUN, 1'b0, 36'o0, 36'o0, 1'b0, 10, 1'b0, 1'b1);
        txn(0, FUNC_IR_STROBE, 1'b0, 36'o254000001000, 36'o0, 1'b0, 0, 1'b0, 1'b0);

        // Reset in the middle of the strobe pulse (cycle 5)
        req_valid[0] = 1'b1; req_func[0] = FUNC_SET_RUN; req_read[0] = 1'b0; req_data[0] = 36'o1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid[0] = 1'b0;
        end
        chk("mid_strobe", diag_strobe[0], 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("abort_strobe", diag_strobe[0], 0);
        chk("abort_ds", ds[0], 0);
        chk("abort_drive", data_drive[0], 0);
        chk("abort_ready", req_ready[0], 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid[0], 0);
        end

        // Fast timing: write, read, then back-to-back strobes with rsp_ready tied high
        txn(1, FUNC_SET_RUN, 1'b0, 36'o5, 36'o0, 1'b0, 0, 1'b0, 1'b0);
        txn(1, FUNC_READ_13X, 1'b1, 36'o0, 36'o707070707070, 1'b0, 0, 1'b0, 1'b0);
        rsp_ready[1] = 1'b1;
        txn(1, FUNC_CONTINUE, 1'b0, 36'o11, 36'o0, 1'b0, 0, 1'b1, 1'b0);
        txn(1, FUNC_DRAM_STROBE, 1'b0, 36'o22, 36'o0, 1'b0, 0, 1'b1, 1'b0);
        rsp_ready[1] = 1'b0;

        // Randomized traffic on both timings
        for (int i = 0; i < 40; i++) begin
            int   u, dl;
            logic rd, er;
            u  = i % 2;
            rd = 1'($urandom);
            dl = $urandom_range(0, 3);
            er = (dl == 0) ? 1'($urandom) : 1'b0;
            txn(u, 7'($urandom), rd, {4'($urandom), $urandom}, {4'($urandom), $urandom},
                1'($urandom), dl, er, 1'($urandom));
            rsp_ready[u] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
